// File: rtl/branch_resolve_unit.sv
// Three-stage branch/jump resolver (S1 decode, S2 operand latch, S3 resolve) feeding
// redirect controls back to the fetch unit and flushing wrong-path instructions.
module branch_resolve_unit #(
    parameter int OFFSET_COMP = 3,
    parameter bit ENABLE_JR   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ifu_pc,
    input  logic [31:0] ifu_ins,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        nPC_sel3,
    output logic        zero3,
    output logic        jmp3,
    output logic [31:0] JUMPER_out3,
    output logic [31:0] Ext_out3,
    output logic        link_valid,
    output logic [31:0] link_pc,
    output logic        redirect
);
    localparam int DATA_W = 32;

    // The fetch unit adds Ext<<2 to branch_pc+16, so the word offset is pre-reduced here.
    function automatic logic [DATA_W-1:0] comp_offset(input logic [15:0] imm);
        logic signed [15:0] adj;
        adj = $signed(imm) - $signed(16'(OFFSET_COMP));
        return {{(DATA_W-16){adj[15]}}, adj};
    endfunction

    logic              vld_p0, vld_p1;
    logic [DATA_W-1:0] pc_p0, ins_p0;
    logic [DATA_W-1:0] pc_p1, ins_p1, rs_p1, rt_p1;

    logic              is_beq, is_bne, is_j, is_jal, is_jr;
    logic              br_nxt, zero_nxt, jmp_nxt;
    logic [DATA_W-1:0] jt_nxt, ext_nxt, lpc_nxt, pc4_p1;

    assign rs_addr  = ins_p0[25:21];
    assign rt_addr  = ins_p0[20:16];
    assign redirect = (nPC_sel3 & zero3) | jmp3;

    // S1 / S2 valid: a redirect turns every younger instruction into a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= !redirect;
            vld_p1 <= vld_p0 && !redirect;
        end
    end

    always_ff @(posedge clk) begin
        pc_p0  <= ifu_pc;
        ins_p0 <= ifu_ins;
        pc_p1  <= pc_p0;
        ins_p1 <= ins_p0;
        rs_p1  <= rs_data;
        rt_p1  <= rt_data;
    end

    // S2 -> S3 decode
    always_comb begin
        pc4_p1   = pc_p1 + 32'd4;
        is_beq   = vld_p1 && (ins_p1[31:26] == 6'h04);
        is_bne   = vld_p1 && (ins_p1[31:26] == 6'h05);
        is_j     = vld_p1 && (ins_p1[31:26] == 6'h02);
        is_jal   = vld_p1 && (ins_p1[31:26] == 6'h03);
        is_jr    = ENABLE_JR && vld_p1 && (ins_p1[31:26] == 6'h00) && (ins_p1[5:0] == 6'h08);
        br_nxt   = is_beq || is_bne;
        zero_nxt = (is_beq && (rs_p1 == rt_p1)) || (is_bne && (rs_p1 != rt_p1));
        jmp_nxt  = is_j || is_jal || is_jr;
        jt_nxt   = '0;
        if (is_j || is_jal) begin
            jt_nxt = {pc4_p1[31:28], ins_p1[25:0], 2'b00};
        end else if (is_jr) begin
            jt_nxt = rs_p1;
        end
        ext_nxt  = br_nxt ? comp_offset(ins_p1[15:0]) : '0;
        lpc_nxt  = vld_p1 ? pc_p1 + 32'd8 : '0;
    end

    // S3: registered outputs, cleared on the flush edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nPC_sel3    <= 1'b0;
            zero3       <= 1'b0;
            jmp3        <= 1'b0;
            link_valid  <= 1'b0;
            JUMPER_out3 <= '0;
            Ext_out3    <= '0;
            link_pc     <= '0;
        end else if (redirect) begin
            nPC_sel3    <= 1'b0;
            zero3       <= 1'b0;
            jmp3        <= 1'b0;
            link_valid  <= 1'b0;
            JUMPER_out3 <= '0;
            Ext_out3    <= '0;
            link_pc     <= '0;
        end else begin
            nPC_sel3    <= br_nxt;
            zero3       <= zero_nxt;
            jmp3        <= jmp_nxt;
            link_valid  <= is_jal;
            JUMPER_out3 <= jt_nxt;
            Ext_out3    <= ext_nxt;
            link_pc     <= lpc_nxt;
        end
    end
endmodule
